// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: fixed-point format, arctangent and gain-compensation
// tables, and the controller state encoding used by the rotation and vectoring blocks.
package cordic_pkg;

  localparam int N         = 9;
  localparam int M         = 23;
  localparam int W         = N + M;
  localparam int MAX_STEPS = 24;
  localparam int CNT_W     = 5;
  localparam int K_W       = 24;
  localparam int K_FRAC    = 23;

  typedef logic signed [W-1:0] fixed_t;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    GAIN
  } state_e;

  localparam fixed_t DEG_90  = 32'sh2D00_0000;
  localparam fixed_t DEG_180 = 32'sh5A00_0000;

  // atan(2^-i) in degrees, Q9.23.
  localparam fixed_t ATAN_DEG [MAX_STEPS] = '{
    32'sd377487360, 32'sd222843801, 32'sd117744544, 32'sd59768969,
    32'sd30000467,  32'sd15014858,  32'sd7509261,   32'sd3754860,
    32'sd1877459,   32'sd938733,    32'sd469367,    32'sd234684,
    32'sd117342,    32'sd58671,     32'sd29335,     32'sd14668,
    32'sd7334,      32'sd3667,      32'sd1833,      32'sd917,
    32'sd458,       32'sd229,       32'sd115,       32'sd57
  };

  // Indexed by step count: prod_{i<n} 1/sqrt(1+2^-2i), unsigned Q1.23.
  localparam logic [K_W-1:0] K_INV [MAX_STEPS+1] = '{
    24'd8388608, 24'd5931642, 24'd5305422, 24'd5147015, 24'd5107269,
    24'd5097323, 24'd5094836, 24'd5094214, 24'd5094059, 24'd5094020,
    24'd5094010, 24'd5094008, 24'd5094007, 24'd5094007, 24'd5094007,
    24'd5094007, 24'd5094007, 24'd5094007, 24'd5094007, 24'd5094007,
    24'd5094007, 24'd5094007, 24'd5094007, 24'd5094007, 24'd5094007
  };

endpackage

// File: rtl/cordic_micro_rotation.sv
// One combinational CORDIC micro-rotation; the caller chooses the direction,
// so the same step serves both rotation and vectoring modes.
module cordic_micro_rotation
  import cordic_pkg::*;
#(
  parameter int unsigned WX = W + 2
) (
  input  logic signed [WX-1:0] x,
  input  logic signed [WX-1:0] y,
  input  fixed_t               z,
  input  logic [CNT_W-1:0]     shift,
  input  logic                 d_neg,
  output logic signed [WX-1:0] x_next,
  output logic signed [WX-1:0] y_next,
  output fixed_t               z_next
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_STEPS - 1);

  logic signed [WX-1:0] x_sh;
  logic signed [WX-1:0] y_sh;
  fixed_t               atan_i;

  // NOTE: every output gets a value on every path, otherwise always_comb infers a latch.
  always_comb begin
    x_sh   = x >>> shift;
    y_sh   = y >>> shift;
    atan_i = (shift <= LAST_IDX) ? ATAN_DEG[shift] : '0;
    if (d_neg) begin
      x_next = x - y_sh;
      y_next = y + x_sh;
      z_next = z - atan_i;
    end else begin
      x_next = x + y_sh;
      y_next = y - x_sh;
      z_next = z + atan_i;
    end
  end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: converts (x, y) to magnitude and atan2 angle
// in degrees, one micro-rotation per clock, one operation in flight.
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int unsigned STEPS = 10,
  parameter int unsigned GUARD = 2
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_en,
  input  logic signed [W-1:0] i_x,
  input  logic signed [W-1:0] i_y,
  output logic [W-1:0]        o_mag,
  output logic signed [W-1:0] o_angle,
  output logic                o_valid,
  output logic                o_busy
);

  localparam int unsigned WX   = W + GUARD;
  localparam int unsigned PW   = WX + K_W + 1;
  localparam int unsigned MF_W = PW - K_FRAC;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(STEPS - 1);
  localparam logic [W-1:0]     MAG_MAX = {1'b0, {(W-1){1'b1}}};

  if (STEPS < 1 || STEPS > MAX_STEPS) begin : g_bad_steps
    $error("cordic_vectoring: STEPS must be 1..24");
  end

  typedef logic signed [WX-1:0] wide_t;

  state_e           state_q, state_d;
  wide_t            x_q, x_d, y_q, y_d;
  fixed_t           z_q, z_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic             zero_q, zero_d;
  logic             neg_axis_q, neg_axis_d;
  logic [W-1:0]     mag_q, mag_d;
  fixed_t           angle_q, angle_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  wide_t            x_ext, y_ext, x_rot, y_rot;
  fixed_t           z_rot;
  logic [MF_W-1:0]  mag_full;
  logic [W-1:0]     sat_mag;

  assign x_ext = wide_t'(i_x);
  assign y_ext = wide_t'(i_y);

  // Vectoring drives y toward zero, so the direction follows the sign of y.
  cordic_micro_rotation #(.WX(WX)) u_step (
    .x      (x_q),
    .y      (y_q),
    .z      (z_q),
    .shift  (iter_q),
    .d_neg  (y_q[WX-1]),
    .x_next (x_rot),
    .y_next (y_rot),
    .z_next (z_rot)
  );

  // Sign-extend both operands to the product width; the low bits of the unsigned
  // product then equal the signed product.
  assign mag_full = MF_W'(({{(K_W+1){x_q[WX-1]}}, x_q} *
                           {{(WX+1){1'b0}}, K_INV[STEPS]}) >> K_FRAC);

  always_comb begin
    if (mag_full[MF_W-1])              sat_mag = '0;
    else if (|mag_full[MF_W-2:W-1])    sat_mag = MAG_MAX;
    else                               sat_mag = {1'b0, mag_full[W-2:0]};
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    z_d        = z_q;
    iter_d     = iter_q;
    zero_d     = zero_q;
    neg_axis_d = neg_axis_q;
    mag_d      = mag_q;
    angle_d    = angle_q;
    valid_d    = 1'b0;
    busy_d     = busy_q;
    unique case (state_q)
      IDLE: begin
        if (i_en) begin
          zero_d     = (i_x == '0) && (i_y == '0);
          neg_axis_d = i_x[W-1] && (i_y == '0);
          // Pre-rotate by +-90 so the iterations only have to cover (-90, +90].
          if (!i_x[W-1]) begin
            x_d = x_ext;
            y_d = y_ext;
            z_d = '0;
          end else if (!i_y[W-1]) begin
            x_d = y_ext;
            y_d = -x_ext;
            z_d = DEG_90;
          end else begin
            x_d = -y_ext;
            y_d = x_ext;
            z_d = -DEG_90;
          end
          iter_d  = '0;
          busy_d  = 1'b1;
          state_d = ITER;
        end
      end
      ITER: begin
        x_d    = x_rot;
        y_d    = y_rot;
        z_d    = z_rot;
        iter_d = iter_q + 1'b1;
        if (iter_q == LAST) state_d = GAIN;
      end
      GAIN: begin
        if (zero_q) begin
          mag_d   = '0;
          angle_d = '0;
        end else begin
          mag_d   = sat_mag;
          angle_d = neg_axis_q ? DEG_180 : z_q;
        end
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      iter_q     <= '0;
      zero_q     <= 1'b0;
      neg_axis_q <= 1'b0;
      mag_q      <= '0;
      angle_q    <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      z_q        <= z_d;
      iter_q     <= iter_d;
      zero_q     <= zero_d;
      neg_axis_q <= neg_axis_d;
      mag_q      <= mag_d;
      angle_q    <= angle_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign o_mag   = mag_q;
  assign o_angle = angle_q;
  assign o_valid = valid_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Bench for cordic_vectoring: directed table, reset abort, back-to-back enable
// and a random sweep, all checked by a scoreboard against a real-valued model.
module tb_cordic_vectoring;
  import cordic_pkg::*;

  localparam int  STEPS   = 10;
  localparam real SCALE   = 8388608.0;
  localparam real LSB     = 1.0 / SCALE;
  localparam real PI      = 3.14159265358979323846;
  localparam real MAG_SAT = 2147483647.0 / SCALE;

  logic                i_clk = 1'b0;
  logic                i_reset;
  logic                i_en;
  logic signed [W-1:0] i_x;
  logic signed [W-1:0] i_y;
  logic [W-1:0]        o_mag;
  logic signed [W-1:0] o_angle;
  logic                o_valid;
  logic                o_busy;

  cordic_vectoring #(.STEPS(STEPS), .GUARD(2)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (i_en),
    .i_x     (i_x),
    .i_y     (i_y),
    .o_mag   (o_mag),
    .o_angle (o_angle),
    .o_valid (o_valid),
    .o_busy  (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic signed [W-1:0] x;
    logic signed [W-1:0] y;
    real                 mag;
    real                 ang;
    bit                  exact_mag;
    bit                  exact_ang;
    int                  exp_edge;
  } sb_item_t;

  typedef struct {
    real x;
    real y;
    real mag;
    real ang;
    bit  exact;
  } vec_t;

  sb_item_t sb[$];
  int       total    = 0;
  int       bad      = 0;
  int       edge_cnt = 0;
  real      ang_tol;

  task automatic check(input string name, input bit ok, input string detail);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  function automatic real abs_r(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  function automatic logic signed [W-1:0] to_fix(input real r);
    return $rtoi(r * SCALE);
  endfunction

  function automatic sb_item_t model(input logic signed [W-1:0] x, input logic signed [W-1:0] y);
    sb_item_t e;
    real xr = real'(x) * LSB;
    real yr = real'(y) * LSB;
    e.x         = x;
    e.y         = y;
    e.mag       = $sqrt(xr * xr + yr * yr);
    e.ang       = $atan2(yr, xr) * 180.0 / PI;
    e.exact_mag = (x == 0) && (y == 0);
    e.exact_ang = (y == 0) && (x <= 0);
    if (e.exact_ang) e.ang = (x < 0) ? 180.0 : 0.0;
    if (e.mag > MAG_SAT) e.mag = MAG_SAT;
    e.exp_edge  = 0;
    return e;
  endfunction

  task automatic compare(input sb_item_t e);
    real got_mag = real'(longint'(o_mag)) * LSB;
    real got_ang = real'(o_angle) * LSB;
    real d;
    check("latency", edge_cnt == e.exp_edge,
          $sformatf("x=%h y=%h o_valid at edge %0d, want edge %0d", e.x, e.y, edge_cnt, e.exp_edge));
    if (e.exact_mag)
      check("mag_exact", o_mag == 0, $sformatf("x=%h y=%h got %h want 0", e.x, e.y, o_mag));
    else
      check("mag", !o_mag[W-1] && (abs_r(got_mag - e.mag) <= e.mag / 2048.0 + 4.0 * LSB),
            $sformatf("x=%h y=%h got %f want %f", e.x, e.y, got_mag, e.mag));
    if (e.exact_ang) begin
      check("angle_exact", o_angle == to_fix(e.ang),
            $sformatf("x=%h y=%h got %h want %h", e.x, e.y, o_angle, to_fix(e.ang)));
    end else begin
      d = got_ang - e.ang;
      if (d > 180.0)   d = d - 360.0;
      if (d <= -180.0) d = d + 360.0;
      check("angle", abs_r(d) <= ang_tol,
            $sformatf("x=%h y=%h got %f want %f deg", e.x, e.y, got_ang, e.ang));
    end
  endtask

  // Scoreboard monitor: samples 1 time unit after every rising edge.
  initial begin
    forever begin
      @(posedge i_clk);
      edge_cnt++;
      #1;
      if (o_valid === 1'b1) begin
        if (sb.size() == 0)
          check("unexpected_valid", 1'b0, $sformatf("o_valid=1 at edge %0d, want 0", edge_cnt));
        else
          compare(sb.pop_front());
      end else if (sb.size() != 0 && edge_cnt >= sb[0].exp_edge) begin
        check("missing_valid", 1'b0,
              $sformatf("o_valid=0 at edge %0d, want 1 for x=%h y=%h", edge_cnt, sb[0].x, sb[0].y));
        void'(sb.pop_front());
      end
    end
  end

  // Drives one operation and returns when the next capture is first allowed.
  task automatic issue(input sb_item_t e);
    @(negedge i_clk);
    i_x        = e.x;
    i_y        = e.y;
    i_en       = 1'b1;
    e.exp_edge = edge_cnt + STEPS + 2;
    sb.push_back(e);
    @(negedge i_clk);
    i_en = 1'b0;
    repeat (STEPS) @(negedge i_clk);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 4 * (STEPS + 2)) begin
      @(negedge i_clk);
      n++;
    end
    check("drain", sb.size() == 0, $sformatf("%0d results pending, want 0", sb.size()));
    sb.delete();
  endtask

  task automatic rand_vec(output logic signed [W-1:0] x, output logic signed [W-1:0] y);
    real xr, yr;
    do begin
      xr = real'(int'($urandom_range(0, 300000)) - 150000) / 1000.0;
      yr = real'(int'($urandom_range(0, 300000)) - 150000) / 1000.0;
    end while (xr * xr + yr * yr < 0.0625);
    x = to_fix(xr);
    y = to_fix(yr);
  endtask

  initial begin
    vec_t                tbl[12];
    sb_item_t            e;
    logic signed [W-1:0] rx, ry;

    ang_tol = $atan(1.0 / real'(1 << (STEPS - 1))) * 180.0 / PI + STEPS * LSB + 0.002;

    tbl[0]  = '{1.0,    1.0,    1.4142135624,  45.0,          1'b0};
    tbl[1]  = '{3.0,   -4.0,    5.0,          -53.1301023542, 1'b0};
    tbl[2]  = '{0.0,    1.0,    1.0,           90.0,          1'b0};
    tbl[3]  = '{-1.0,   0.0,    1.0,           180.0,         1'b1};
    tbl[4]  = '{0.0,   -1.0,    1.0,          -90.0,          1'b0};
    tbl[5]  = '{0.0,    0.0,    0.0,           0.0,           1'b1};
    tbl[6]  = '{-256.0, 0.0,    256.0,         180.0,         1'b1};
    tbl[7]  = '{-256.0, -256.0, 362.0386719,  -135.0,         1'b0};
    tbl[8]  = '{200.0,  200.0,  282.8427125,   45.0,          1'b0};
    tbl[9]  = '{-2.5,   3.25,   4.1003048668,  127.5685920288, 1'b0};
    tbl[10] = '{0.5,   -1.0,    1.1180339887, -63.4349488229, 1'b0};
    tbl[11] = '{-100.0, -0.5,   100.0012500,  -179.7135216500, 1'b0};

    i_reset = 1'b1;
    i_en    = 1'b0;
    i_x     = '0;
    i_y     = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_mag",   o_mag == 0,      $sformatf("got %h want 0", o_mag));
    check("reset_angle", o_angle == 0,    $sformatf("got %h want 0", o_angle));
    check("reset_valid", o_valid == 1'b0, $sformatf("got %b want 0", o_valid));
    check("reset_busy",  o_busy == 1'b0,  $sformatf("got %b want 0", o_busy));
    @(negedge i_clk);
    i_reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      e.x         = to_fix(tbl[i].x);
      e.y         = to_fix(tbl[i].y);
      e.mag       = (tbl[i].mag > MAG_SAT) ? MAG_SAT : tbl[i].mag;
      e.ang       = tbl[i].ang;
      e.exact_ang = tbl[i].exact;
      e.exact_mag = tbl[i].exact && (tbl[i].mag == 0.0);
      issue(e);
    end
    drain();

    // Abort: reset taken at the fifth edge after capture.
    @(negedge i_clk);
    i_x  = to_fix(2.0);
    i_y  = to_fix(-7.0);
    i_en = 1'b1;
    @(negedge i_clk);
    i_en = 1'b0;
    repeat (3) @(negedge i_clk);
    check("busy_mid_op", o_busy == 1'b1, $sformatf("got %b want 1", o_busy));
    @(negedge i_clk);
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    check("abort_busy",  o_busy == 1'b0,  $sformatf("got %b want 0", o_busy));
    check("abort_mag",   o_mag == 0,      $sformatf("got %h want 0", o_mag));
    check("abort_angle", o_angle == 0,    $sformatf("got %h want 0", o_angle));
    check("abort_valid", o_valid == 1'b0, $sformatf("got %b want 0", o_valid));
    @(negedge i_clk);
    i_reset = 1'b0;
    repeat (STEPS + 4) @(negedge i_clk);
    issue(model(to_fix(-6.0), to_fix(8.0)));
    drain();

    // i_en held high: only the inputs present at each idle edge are captured.
    @(negedge i_clk);
    for (int k = 0; k < 4 * (STEPS + 2); k++) begin
      rand_vec(rx, ry);
      i_x  = rx;
      i_y  = ry;
      i_en = 1'b1;
      if (k % (STEPS + 2) == 0) begin
        e          = model(rx, ry);
        e.exp_edge = edge_cnt + STEPS + 2;
        sb.push_back(e);
      end
      @(negedge i_clk);
    end
    i_en = 1'b0;
    drain();

    for (int n = 0; n < 1000; n++) begin
      rand_vec(rx, ry);
      issue(model(rx, ry));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cordic_vectoring.md
Name: cordic_vectoring

Overview:
- Vectoring-mode CORDIC, the inverse of the existing rotation-mode block.
- Takes a Cartesian vector (x, y) and returns its magnitude and angle atan2(y, x) in degrees.
- Both use the same signed fixed-point format as the rotation block.
- Iterative architecture: one micro-rotation per clock. One operation in flight at a time, started by a single-cycle enable.

Parameters:
- N, 9, integer bits including sign.
- M, 23, fractional bits. Word width W = N+M.
- STEPS, 10, number of micro-rotations. Legal range 1..24.
- GUARD, 2, extra MSBs on internal x/y datapath to absorb CORDIC growth.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_en  in  1  start pulse; sampled only when o_busy=0.
- i_x  in  W  signed Q(N).(M) x component.
- i_y  in  W  signed Q(N).(M) y component.
- o_mag  out  W  unsigned-valued magnitude in Q(N).(M); MSB always 0.
- o_angle  out  W  signed Q(N).(M) degrees, range (-180, +180].
- o_valid  out  1  one-cycle pulse; o_mag/o_angle valid while high and held until next o_valid.
- o_busy  out  1  operation in progress.

Behaviour:
- Reset:
  - o_mag=0, o_angle=0, o_valid=0, o_busy=0.
  - Internal x/y/z, iteration counter and state cleared.
  - Reset mid-operation aborts it and no o_valid is produced.
- States: IDLE -> ITER -> GAIN -> IDLE.
- Capture edge (IDLE, i_en=1):
  - Sign-extend inputs to W+GUARD and apply quadrant pre-rotation.
  - x>=0: x'=x, y'=y, z=0.
  - x<0, y>=0: x'=y, y'=-x, z=+90.
  - x<0, y<0: x'=-y, y'=x, z=-90.
  - o_busy goes 1; counter i=0.
- ITER, one step per edge for i=0..STEPS-1:
  - d = (y>=0) ? +1 : -1.
  - x <= x + d*(y>>>i); y <= y - d*(x>>>i); z <= z + d*ATAN[i].
  - Shifts are arithmetic; sums are truncated and never saturate internally.
- GAIN edge:
  - o_mag <= (x * K_INV[STEPS]) >> M.
  - Product is full-width, then truncated; saturates to 2^(W-1)-1 if it exceeds the positive range.
  - o_angle <= z; o_valid <= 1; o_busy <= 0.
- Latency:
  - o_valid rises exactly STEPS+1 edges after the capture edge (11 for defaults).
  - o_valid is high for exactly 1 cycle.
  - Earliest next capture is the edge after o_valid rises, giving throughput of 1 result per STEPS+2 cycles.
- i_en while o_busy=1 is ignored: no queuing, no error flag.
- Special cases:
  - x=0, y=0: o_mag=0, o_angle=0 exactly (forced at GAIN edge).
  - x<0, y=0: o_angle=+180 exactly; the iteration result is overridden to 180<<M.
  - Most-negative input (-2^(N-1)) is negated within the guard bits without overflow.
- Accuracy:
  - Angle: |err| <= atan(2^-(STEPS-1)) + STEPS LSB (~0.113 deg at STEPS=10).
  - Magnitude: relative err <= 2^-11 + 4 LSB for magnitudes >= 2^-8.

Decomposition:
- Extend the shared package cordic_pkg with:
  - fixed-point typedef parameterised by N/M;
  - ATAN_DEG table, 24 entries, atan(2^-i) in degrees as Q9.23 constants;
  - K_INV table indexed by STEPS, prod 1/sqrt(1+2^-2i), Q1.23;
  - state enum {IDLE, ITER, GAIN}.
- The rotation block must use these same tables.
- One natural sub-module: cordic_micro_rotation.
  - Combinational single step with inputs x, y, z, shift i, direction d.
  - Shared with the rotation block; the vectoring/rotation direction rule is computed outside it.

Test Plan:
- x=1.0, y=1.0 (0x00800000 each), i_en 1 cycle -> o_valid exactly 11 cycles after capture edge; o_mag≈0x00B504F3 (1.41421); o_angle≈0x16800000 (45.0); within tolerance.
- x=3.0, y=-4.0 -> o_mag≈5.0 (0x02800000); o_angle≈-53.1301 deg (0xE56F5BD8 region, tol ±0.113 deg).
- Axis cases:
  - (0,1) -> angle 90.0, mag 1.0.
  - (-1,0) -> angle exactly 0x5A000000 (+180).
  - (0,-1) -> -90.0.
  - (0,0) -> mag 0, angle 0 exactly.
- Reset asserted 5 cycles after capture -> o_busy=0 and outputs 0 next cycle; no o_valid pulse ever appears for that operation; a new op after reset completes normally.
- i_en held high continuously with changing inputs -> only values present at each IDLE capture edge are processed; results spaced STEPS+2 cycles apart; exactly one o_valid per capture.
- Randomised sweep of 1000 vectors vs real-valued atan2/hypot model -> all within accuracy bounds; no saturation except inputs with |v|·1.0 near 2^(N-1).
